// File: rtl/apb_timer_master.sv
// APB requester for the timer completer port: turns single valid/ready commands into
// SETUP/ACCESS transfers and returns read data / error status through a one-deep response register.
`timescale 1ns/1ps
module apb_timer_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic                tim_pready,
  input  logic                tim_pslverr,
  input  logic [DATA_W-1:0]   tim_prdata
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic [ADDR_W-1:0]    paddr_q;
  logic [DATA_W-1:0]    pwdata_q;
  logic [DATA_W/8-1:0]  pstrb_q;
  logic                 rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic                 rsp_err_q;
  logic                 rsp_timeout_q;
  logic                 accept;
  logic                 done_ok;
  logic                 done_to;

  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  // cnt_d is the wait count including the current pready-low cycle; it saturates
  assign cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign done_ok = (state_q == ACCESS) && tim_pready;
  assign done_to = (state_q == ACCESS) && !tim_pready && (TIMEOUT != 0) && (cnt_d == CNT_LIMIT);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // a completion on the same edge as a consume overwrites the old response
      if (done_ok || done_to) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= (done_ok && !pwrite_q) ? tim_prdata : '0;
        rsp_err_q     <= done_to | tim_pslverr;
        rsp_timeout_q <= done_to;
      end else if (rsp_ready) begin
        rsp_valid_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_wdata;
            pstrb_q   <= cmd_write ? cmd_strb : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (done_ok || done_to) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb_timer_master.md
# apb_timer_master

APB requester that drives the timer's APB completer port (tim_p* signals) from a simple valid/ready command stream and returns each transfer's read data and error status on a valid/ready response stream. It sits between a host-side sequencer (or test/firmware model) and the timer top, converting single commands into compliant SETUP/ACCESS APB transfers. It tolerates completer wait states and aborts with an error when pready never arrives.

## Interface
Parameters:
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width (strobe width is DATA_W/8)
- TIMEOUT, 255, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
- sys_clk  in  1  single clock, all logic rising-edge
- sys_rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clock edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at clock edge
- rsp_rdata  out  DATA_W  captured tim_prdata (0 for writes and timeouts)
- rsp_err  out  1  tim_pslverr sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by timeout
- tim_psel, tim_penable, tim_pwrite  out  1  APB control
- tim_paddr  out  ADDR_W; tim_pwdata  out  DATA_W; tim_pstrb  out  DATA_W/8
- tim_pready, tim_pslverr  in  1; tim_prdata  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = !rsp_valid | rsp_ready. On accept, register write/addr/wdata/strb into APB output regs; go SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle; go ACCESS.
- ACCESS: psel=1, penable=1; wait-cycle counter increments each cycle tim_pready=0.
  - tim_pready=1: load response regs (rdata = write ? 0 : tim_prdata, err = tim_pslverr, timeout=0), set rsp_valid, go IDLE.
  - TIMEOUT!=0 and counter == TIMEOUT with pready=0: abort; response rdata=0, err=1, timeout=1; go IDLE.
- tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb held stable from SETUP through final ACCESS cycle and retained in IDLE (no glitching to X).
- Reads drive tim_pstrb = 0 regardless of cmd_strb.
- Response register is one deep; rsp_valid clears on rsp_ready unless a new completion loads the same edge (new response wins, rsp_valid stays 1).
- cmd_ready is 0 in SETUP and ACCESS; no new command accepted while a response is pending and not being consumed.
- Wait counter width: clog2(TIMEOUT+1), min 1; cleared on entry to SETUP; saturates, never wraps.

## Timing
- Reset (async assert, sync-released by the system): state IDLE, all tim_p* outputs 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_timeout 0, counter 0, cmd_ready 1 after reset deasserts. Reset mid-transfer drops psel/penable immediately; no response is produced for the interrupted command.
- Accept at edge T: SETUP in cycle T+1, ACCESS from T+2.
- Zero-wait transfer: rsp_valid high in cycle T+3; N wait states: T+3+N.
- Back-to-back: with rsp_ready held 1 and cmd_valid held 1, next command accepted at the completion edge's following IDLE cycle; throughput one transfer per 3 cycles (psel drops for one IDLE cycle between transfers).
- Timeout: with pready held 0, abort edge is the end of the (TIMEOUT)th ACCESS cycle; rsp_valid high next cycle; psel/penable 0 that same cycle.
- Responses stay stable while rsp_valid=1 and rsp_ready=0.

## Test plan
- Reset: assert sys_rst mid-ACCESS -> psel/penable/rsp_valid drop to 0 same cycle without clock edge; after release cmd_ready=1.
- Zero-wait write addr 0x000, wdata 0x0000_0003, strb 0xF -> SETUP then ACCESS cycles with stable bus, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 0x004 with completer inserting 2 wait states, prdata 0xDEAD_BEEF, cmd_strb 0xF -> tim_pstrb=0 throughout, rsp_valid 5 cycles after accept, rsp_rdata=0xDEAD_BEEF.
- Completer returns pslverr=1 on write to 0xFFF -> rsp_err=1, rsp_timeout=0, FSM back to IDLE.
- TIMEOUT=4, pready stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command proceeds normally.
- Backpressure: rsp_ready=0 for 10 cycles with cmd_valid held -> cmd_ready=0, response stable; on rsp_ready=1 the next command is accepted the same edge.
